// File: rtl/rtc_pkg.sv
// -----------------------------------------------------------------------------
// rtc_pkg
// Shared definitions for the RTC multiplexed-bus controller:
//   - rtc_state_e : 3-bit bus-cycle state encoding (IDLE=0 ... GAP=7)
//   - rtc_op_e    : transaction opcode bit (OP_WRITE / OP_READ)
//   - rtc_bus_t   : bundle of every registered RTC bus output
//   - reset-value constants and helpers that map a state to its bus levels
// -----------------------------------------------------------------------------
package rtc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_A_SETUP = 3'd1,
    ST_A_STRB  = 3'd2,
    ST_A_HOLD  = 3'd3,
    ST_D_SETUP = 3'd4,
    ST_D_STRB  = 3'd5,
    ST_D_HOLD  = 3'd6,
    ST_GAP     = 3'd7
  } rtc_state_e;

  typedef enum logic {
    OP_WRITE = 1'b0,
    OP_READ  = 1'b1
  } rtc_op_e;

  typedef struct packed {
    logic       cs_n;
    logic       ad_sel;
    logic       wr_n;
    logic       rd_n;
    logic [7:0] ad_o;
    logic       ad_oe;
  } rtc_bus_t;

  // Quiescent bus: chip deselected, strobes high, AD bus released.
  localparam rtc_bus_t BUS_RESET = '{
    cs_n:   1'b1,
    ad_sel: 1'b0,
    wr_n:   1'b1,
    rd_n:   1'b1,
    ad_o:   8'h00,
    ad_oe:  1'b0
  };

  localparam logic [7:0] RDATA_RESET = 8'h00;
  localparam logic [7:0] ADDR_RESET  = 8'h00;
  localparam logic [7:0] DATA_RESET  = 8'h00;

  // Fixed walk through the bus cycle; GAP returns to IDLE.
  function automatic rtc_state_e next_state(input rtc_state_e st);
    rtc_state_e nxt;
    case (st)
      ST_A_SETUP: nxt = ST_A_STRB;
      ST_A_STRB:  nxt = ST_A_HOLD;
      ST_A_HOLD:  nxt = ST_D_SETUP;
      ST_D_SETUP: nxt = ST_D_STRB;
      ST_D_STRB:  nxt = ST_D_HOLD;
      ST_D_HOLD:  nxt = ST_GAP;
      default:    nxt = ST_IDLE;
    endcase
    return nxt;
  endfunction

  // Bus levels for a given state. The address phase strobes rtc_wr_n for both
  // opcodes (it latches the address inside the RTC); the data phase strobes
  // rtc_wr_n for writes and rtc_rd_n for reads, so the two never overlap.
  function automatic rtc_bus_t bus_drive(input rtc_state_e st,
                                         input rtc_op_e    op,
                                         input logic [7:0] addr,
                                         input logic [7:0] data);
    rtc_bus_t b;
    b = BUS_RESET;
    case (st)
      ST_A_SETUP, ST_A_STRB, ST_A_HOLD: begin
        b.cs_n   = 1'b0;
        b.ad_sel = 1'b0;
        b.ad_o   = addr;
        b.ad_oe  = 1'b1;
        b.wr_n   = (st != ST_A_STRB);
      end
      ST_D_SETUP, ST_D_STRB, ST_D_HOLD: begin
        b.cs_n   = 1'b0;
        b.ad_sel = 1'b1;
        if (op == OP_WRITE) begin
          b.ad_o  = data;
          b.ad_oe = 1'b1;
          b.wr_n  = (st != ST_D_STRB);
        end else begin
          // AD bus released from D_SETUP on: a full phase of turnaround
          // before the RTC starts driving in D_STRB.
          b.rd_n = (st != ST_D_STRB);
        end
      end
      default: ;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/rtc_phase_timer.sv
// -----------------------------------------------------------------------------
// rtc_phase_timer
// 8-bit load/decrement counter used to time bus phases and the inter-
// transaction gap. Loads on load_i, otherwise counts down and parks at zero.
//   clk        : system clock
//   reset      : synchronous, active-high reset (counter -> 0)
//   load_i     : load load_val_i this cycle
//   load_val_i : value to load (phase length minus one)
//   done_o     : counter is zero (current phase is in its last cycle)
// -----------------------------------------------------------------------------
module rtc_phase_timer (
  input  logic       clk,
  input  logic       reset,
  input  logic       load_i,
  input  logic [7:0] load_val_i,
  output logic       done_o
);

  logic [7:0] cnt_q;

  // NOTE: sequential state is assigned with <= only, so every register in the
  // design samples its inputs from the same pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= 8'h00;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != 8'h00) begin
      cnt_q <= cnt_q - 8'd1;
    end
  end

  assign done_o = (cnt_q == 8'h00);

endmodule

// File: rtl/rtc_bus_ctrl.sv
// -----------------------------------------------------------------------------
// rtc_bus_ctrl
// Turns PicoBlaze port accesses (decoded by actRTC/dir) into timed
// multiplexed address/data bus cycles to an external RTC chip. Reads are
// prefetched: an INPUT launches a bus read of dir, and the value the processor
// sees on rdata is the result of the previous completed read.
//   clk, reset     : system clock, synchronous active-high reset
//   act            : RTC select from the port decoder
//   dir            : RTC register address
//   wdata          : processor write data (out_port)
//   write_strobe   : processor write strobe
//   read_strobe    : processor read strobe
//   rdata          : last completed read data (to in_portRTC)
//   busy           : transaction in progress
//   req_lost       : one-cycle pulse when a request is dropped
//   rtc_cs_n       : RTC chip select, active low
//   rtc_ad_sel     : 0 = address phase, 1 = data phase
//   rtc_wr_n       : RTC write strobe, active low
//   rtc_rd_n       : RTC read strobe, active low
//   rtc_ad_o       : value for the AD bus
//   rtc_ad_oe      : AD bus output enable (tristate lives at the top level)
//   rtc_ad_i       : AD bus input
// -----------------------------------------------------------------------------
module rtc_bus_ctrl
  import rtc_pkg::*;
#(
  parameter int unsigned PH_CYC  = 8,
  parameter int unsigned GAP_CYC = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       act,
  input  logic [7:0] dir,
  input  logic [7:0] wdata,
  input  logic       write_strobe,
  input  logic       read_strobe,
  output logic [7:0] rdata,
  output logic       busy,
  output logic       req_lost,
  output logic       rtc_cs_n,
  output logic       rtc_ad_sel,
  output logic       rtc_wr_n,
  output logic       rtc_rd_n,
  output logic [7:0] rtc_ad_o,
  output logic       rtc_ad_oe,
  input  logic [7:0] rtc_ad_i
);

  localparam logic [7:0] PH_LOAD  = 8'(PH_CYC - 1);
  localparam logic [7:0] GAP_LOAD = 8'(GAP_CYC - 1);

  rtc_state_e state_q, state_d;
  rtc_op_e    op_q, op_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] data_q, data_d;
  rtc_bus_t   bus_q, bus_d;
  logic       busy_q;
  logic       req_lost_q, req_lost_d;
  logic [7:0] rdata_q;

  logic       strobe_any;
  logic       accept;
  logic       advance;
  logic       capture;
  logic       tmr_load;
  logic [7:0] tmr_val;
  logic       tmr_done;

  rtc_phase_timer u_timer (
    .clk        (clk),
    .reset      (reset),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .done_o     (tmr_done)
  );

  // NOTE: every signal gets a default at the top of the block so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    addr_d     = addr_q;
    data_d     = data_q;

    strobe_any = act && (write_strobe || read_strobe);
    accept     = (state_q == ST_IDLE) && strobe_any;
    advance    = (state_q != ST_IDLE) && tmr_done;

    if (accept) begin
      state_d = ST_A_SETUP;
      // Write wins a same-cycle collision; the read is reported via req_lost.
      op_d    = write_strobe ? OP_WRITE : OP_READ;
      addr_d  = dir;
      data_d  = wdata;
    end else if (advance) begin
      state_d = next_state(state_q);
    end

    // Reload on every state entry except the return to IDLE, where the
    // counter is already parked at zero.
    tmr_load   = accept || (advance && (state_q != ST_GAP));
    tmr_val    = (state_d == ST_GAP) ? GAP_LOAD : PH_LOAD;

    req_lost_d = strobe_any &&
                 ((state_q != ST_IDLE) || (write_strobe && read_strobe));

    // Sample the RTC on the last clock of D_STRB, while rtc_rd_n is still low.
    capture    = (state_q == ST_D_STRB) && tmr_done && (op_q == OP_READ);

    // Outputs are computed from the next state and registered, so the pins
    // change exactly on state entry and never glitch.
    bus_d      = bus_drive(state_d, op_d, addr_d, data_d);
  end

  // NOTE: reset clears every register here, including the read-data and
  // address/data latches, so no stale transaction survives an abort.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      op_q       <= OP_WRITE;
      addr_q     <= ADDR_RESET;
      data_q     <= DATA_RESET;
      bus_q      <= BUS_RESET;
      busy_q     <= 1'b0;
      req_lost_q <= 1'b0;
      rdata_q    <= RDATA_RESET;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      bus_q      <= bus_d;
      busy_q     <= (state_d != ST_IDLE);
      req_lost_q <= req_lost_d;
      if (capture) begin
        rdata_q <= rtc_ad_i;
      end
    end
  end

  assign rdata      = rdata_q;
  assign busy       = busy_q;
  assign req_lost   = req_lost_q;
  assign rtc_cs_n   = bus_q.cs_n;
  assign rtc_ad_sel = bus_q.ad_sel;
  assign rtc_wr_n   = bus_q.wr_n;
  assign rtc_rd_n   = bus_q.rd_n;
  assign rtc_ad_o   = bus_q.ad_o;
  assign rtc_ad_oe  = bus_q.ad_oe;

endmodule

// File: tb/tb_rtc_bus_ctrl.sv
// -----------------------------------------------------------------------------
// tb_rtc_bus_ctrl
// Self-checking bench for rtc_bus_ctrl (PH_CYC=2, GAP_CYC=2). Expected bus
// levels are derived per cycle from the transaction offset: phase = k/PH_CYC,
// address phases 0..2, data phases 3..5, strobe in phases 1 and 4, then GAP.
// A simple RTC model drives rtc_ad_i only while rtc_rd_n is low.
// -----------------------------------------------------------------------------
module tb_rtc_bus_ctrl;

  localparam int PH  = 2;
  localparam int GP  = 2;
  localparam int LAT = 6 * PH + GP;
  localparam bit OPW = 1'b0;
  localparam bit OPR = 1'b1;

  logic       clk = 1'b0;
  logic       reset;
  logic       act;
  logic [7:0] dir;
  logic [7:0] wdata;
  logic       write_strobe;
  logic       read_strobe;
  logic [7:0] rdata;
  logic       busy;
  logic       req_lost;
  logic       rtc_cs_n;
  logic       rtc_ad_sel;
  logic       rtc_wr_n;
  logic       rtc_rd_n;
  logic [7:0] rtc_ad_o;
  logic       rtc_ad_oe;
  logic [7:0] rtc_ad_i;
  logic [7:0] bus_rd_val;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_rdata;

  rtc_bus_ctrl #(.PH_CYC(PH), .GAP_CYC(GP)) dut (
    .clk          (clk),
    .reset        (reset),
    .act          (act),
    .dir          (dir),
    .wdata        (wdata),
    .write_strobe (write_strobe),
    .read_strobe  (read_strobe),
    .rdata        (rdata),
    .busy         (busy),
    .req_lost     (req_lost),
    .rtc_cs_n     (rtc_cs_n),
    .rtc_ad_sel   (rtc_ad_sel),
    .rtc_wr_n     (rtc_wr_n),
    .rtc_rd_n     (rtc_rd_n),
    .rtc_ad_o     (rtc_ad_o),
    .rtc_ad_oe    (rtc_ad_oe),
    .rtc_ad_i     (rtc_ad_i)
  );

  always #5 clk = ~clk;

  // RTC model: drives the addressed register only while it is being read.
  assign rtc_ad_i = rtc_rd_n ? 8'hEE : bus_rd_val;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_quiet(input string tag, input bit exp_lost, input logic [7:0] exp_rd);
    check({tag, "_busy"},     busy,      8'd0);
    check({tag, "_cs_n"},     rtc_cs_n,  8'd1);
    check({tag, "_wr_n"},     rtc_wr_n,  8'd1);
    check({tag, "_rd_n"},     rtc_rd_n,  8'd1);
    check({tag, "_ad_oe"},    rtc_ad_oe, 8'd0);
    check({tag, "_req_lost"}, req_lost,  8'(exp_lost));
    check({tag, "_rdata"},    rdata,     exp_rd);
  endtask

  // Launch one transaction at the current negedge and check every cycle.
  // both     : raise read_strobe together with write_strobe
  // collide_k: raise a stray read_strobe after observing cycle collide_k
  // abort_k  : assert reset after observing cycle abort_k
  task automatic run_txn(input bit op, input logic [7:0] addr, input logic [7:0] data,
                         input logic [7:0] rdv, input bit both,
                         input int collide_k, input int abort_k);
    bit is_wr;
    is_wr        = (op == OPW) || both;
    act          = 1'b1;
    dir          = addr;
    wdata        = data;
    write_strobe = is_wr;
    read_strobe  = (op == OPR) || both;
    bus_rd_val   = rdv;
    for (int k = 0; k < LAT; k++) begin
      int p;
      bit dph;
      @(negedge clk);
      write_strobe = 1'b0;
      read_strobe  = 1'b0;
      dir          = 8'($urandom);
      wdata        = 8'($urandom);
      if (k == 5 * PH && !is_wr) exp_rdata = rdv;
      check("busy", busy, 8'd1);
      check("req_lost", req_lost,
            8'((both && k == 0) || (collide_k >= 0 && k == collide_k + 1)));
      check("rdata", rdata, exp_rdata);
      if (k < 6 * PH) begin
        p   = k / PH;
        dph = (p >= 3);
        check("cs_n",   rtc_cs_n,   8'd0);
        check("ad_sel", rtc_ad_sel, 8'(dph));
        check("wr_n",   rtc_wr_n,   8'(!(p == 1 || (p == 4 && is_wr))));
        check("rd_n",   rtc_rd_n,   8'(!(p == 4 && !is_wr)));
        check("ad_oe",  rtc_ad_oe,  8'(!dph || is_wr));
        if (!dph)       check("ad_o_addr", rtc_ad_o, addr);
        else if (is_wr) check("ad_o_data", rtc_ad_o, data);
      end else begin
        check("gap_cs_n",  rtc_cs_n,  8'd1);
        check("gap_wr_n",  rtc_wr_n,  8'd1);
        check("gap_rd_n",  rtc_rd_n,  8'd1);
        check("gap_ad_oe", rtc_ad_oe, 8'd0);
      end
      if (k == collide_k) begin
        act         = 1'b1;
        read_strobe = 1'b1;
      end
      if (k == abort_k) begin
        reset = 1'b1;
        @(negedge clk);
        reset     = 1'b0;
        exp_rdata = 8'h00;
        check_quiet("abort", 1'b0, exp_rdata);
        return;
      end
    end
    @(negedge clk);
    check_quiet("done", 1'b0, exp_rdata);
  endtask

  initial begin
    reset        = 1'b1;
    act          = 1'b0;
    dir          = 8'h00;
    wdata        = 8'h00;
    write_strobe = 1'b0;
    read_strobe  = 1'b0;
    bus_rd_val   = 8'h00;
    exp_rdata    = 8'h00;

    repeat (2) @(negedge clk);
    check_quiet("reset", 1'b0, 8'h00);
    check("reset_ad_sel", rtc_ad_sel, 8'd0);
    check("reset_ad_o",   rtc_ad_o,   8'h00);
    reset = 1'b0;
    @(negedge clk);
    check_quiet("idle", 1'b0, 8'h00);

    // Directed write, then two back-to-back prefetched reads.
    run_txn(OPW, 8'h21, 8'h45, 8'h00, 1'b0, -1, -1);
    run_txn(OPR, 8'h22, 8'h00, 8'h37, 1'b0, -1, -1);
    run_txn(OPR, 8'h23, 8'h00, 8'h5A, 1'b0, -1, -1);

    // Stray read during a write, then simultaneous strobes in IDLE.
    run_txn(OPW, 8'h30, 8'h99, 8'h00, 1'b0, 2, -1);
    run_txn(OPW, 8'h31, 8'h66, 8'h11, 1'b1, -1, -1);

    // Select gating: strobe without act does nothing.
    act          = 1'b0;
    write_strobe = 1'b1;
    read_strobe  = 1'b0;
    dir          = 8'h55;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      write_strobe = 1'b0;
      check_quiet("gated", 1'b0, exp_rdata);
    end

    // Randomized transactions.
    for (int i = 0; i < 8; i++) begin
      run_txn(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 8'($urandom),
              1'b0, -1, -1);
    end

    // Reset in the first D_STRB cycle of a read, then an immediate write.
    run_txn(OPR, 8'h40, 8'h00, 8'h77, 1'b0, -1, 4 * PH);
    run_txn(OPW, 8'h41, 8'h42, 8'h00, 1'b0, -1, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
